mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline. Consumes the MEM-side outputs of the EXE/MEM register, performs word loads and stores against an internal data memory, and selects the write-back value. Also flags misaligned accesses. Registers the result for the WB stage, which writes the register file.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/data_memory.sv | 22 ++
 rtl/mem_wb_stage.sv | 102 ++++++++++
 tb/tb_mem_wb_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: write-back source codes and the hardwired-zero register.
package pipeline_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_RSVD = 2'b11;  // reserved; treated as ALU result

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A word access is misaligned when either of the low byte-address bits is set.
  function automatic logic word_misaligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: combinational read, write on the rising edge.
// Contents are deliberately not reset.
module data_memory #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: word load/store, alignment check,
// write-back select, link address and a sticky fault address.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_b,
  input  logic [31:0] MEM_c,
  input  logic [4:0]  MEM_num_write,
  input  logic        MEM_mem_write,
  input  logic        MEM_reg_write,
  input  logic [1:0]  MEM_s_data_write,
  output logic [31:0] WB_data,
  output logic [4:0]  WB_num_write,
  output logic        WB_reg_write,
  output logic [31:0] WB_pc,
  output logic        WB_fault,
  output logic [31:0] fault_addr
);

  logic                  is_load;
  logic                  fault;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [31:0]           mem_rdata;
  logic [31:0]           link_addr;
  logic [31:0]           wb_data_d;
  logic                  wb_reg_write_d;

  logic [31:0] wb_data_q;
  logic [4:0]  wb_num_write_q;
  logic        wb_reg_write_q;
  logic [31:0] wb_pc_q;
  logic        wb_fault_q;
  logic [31:0] fault_addr_q;

  // Upper address bits are dropped so accesses wrap modulo memory size.
  assign mem_idx   = MEM_c[ADDR_WIDTH+1:2];
  assign is_load   = (MEM_s_data_write == WB_SEL_MEM);
  assign fault     = word_misaligned(MEM_c) && (MEM_mem_write || is_load);
  // A faulting store, or any store in a reset cycle, must leave memory untouched.
  assign mem_we    = MEM_mem_write && !fault && !reset;
  assign link_addr = MEM_pc + 32'd4;

  data_memory #(.ADDR_WIDTH(ADDR_WIDTH)) u_dmem (
    .clk_i   (clock),
    .we_i    (mem_we),
    .addr_i  (mem_idx),
    .wdata_i (MEM_b),
    .rdata_o (mem_rdata)
  );

  // Write-back source select; the reserved code falls back to the ALU result.
  always_comb begin
    wb_data_d = MEM_c;
    unique case (MEM_s_data_write)
      WB_SEL_ALU:  wb_data_d = MEM_c;
      WB_SEL_MEM:  wb_data_d = mem_rdata;
      WB_SEL_LINK: wb_data_d = link_addr;
      WB_SEL_RSVD: wb_data_d = MEM_c;
      default:     wb_data_d = MEM_c;
    endcase
  end

  // r0 is never written, nor is any register on a faulting access.
  assign wb_reg_write_d = MEM_reg_write && (MEM_num_write != REG_ZERO) && !fault;

  // MEM/WB pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_data_q      <= '0;
      wb_num_write_q <= '0;
      wb_reg_write_q <= 1'b0;
      wb_pc_q        <= '0;
      wb_fault_q     <= 1'b0;
    end else begin
      wb_data_q      <= wb_data_d;
      wb_num_write_q <= MEM_num_write;
      wb_reg_write_q <= wb_reg_write_d;
      wb_pc_q        <= MEM_pc;
      wb_fault_q     <= fault;
    end
  end

  // Sticky capture of the most recent misaligned address.
  always_ff @(posedge clock) begin
    if (reset)      fault_addr_q <= '0;
    else if (fault) fault_addr_q <= MEM_c;
  end

  assign WB_data      = wb_data_q;
  assign WB_num_write = wb_num_write_q;
  assign WB_reg_write = wb_reg_write_q;
  assign WB_pc        = wb_pc_q;
  assign WB_fault     = wb_fault_q;
  assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: behavioural model checked every cycle plus
// hand-computed literal checks from the directed vectors.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] MEM_pc, MEM_b, MEM_c;
  logic [4:0]  MEM_num_write;
  logic        MEM_mem_write, MEM_reg_write;
  logic [1:0]  MEM_s_data_write;
  logic [31:0] WB_data, WB_pc, fault_addr;
  logic [4:0]  WB_num_write;
  logic        WB_reg_write, WB_fault;

  mem_wb_stage #(.ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset),
    .MEM_pc(MEM_pc), .MEM_b(MEM_b), .MEM_c(MEM_c),
    .MEM_num_write(MEM_num_write), .MEM_mem_write(MEM_mem_write),
    .MEM_reg_write(MEM_reg_write), .MEM_s_data_write(MEM_s_data_write),
    .WB_data(WB_data), .WB_num_write(WB_num_write), .WB_reg_write(WB_reg_write),
    .WB_pc(WB_pc), .WB_fault(WB_fault), .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: memory as a sparse word map (unwritten words are unknown).
  bit [31:0] mmem [int unsigned];
  bit        chk_en = 1'b0;
  bit        e_data_known;
  bit [31:0] e_data, e_pc, e_faddr;
  bit [4:0]  e_num;
  bit        e_rw, e_fault;

  // Advance the model by one instruction, straight from the block's rules.
  task automatic model_step();
    int unsigned idx;
    bit mis;
    if (reset) begin
      e_data = 0; e_data_known = 1; e_num = 0; e_rw = 0; e_pc = 0; e_fault = 0; e_faddr = 0;
      return;
    end
    idx = (MEM_c / 4) % 1024;
    mis = (MEM_c % 4 != 0) && (MEM_mem_write || MEM_s_data_write == 2'd1);
    e_data_known = 1;
    if (MEM_s_data_write == 2'd1) begin
      if (mmem.exists(idx)) e_data = mmem[idx];
      else e_data_known = 0;
    end else if (MEM_s_data_write == 2'd2) e_data = MEM_pc + 32'd4;
    else e_data = MEM_c;
    e_num   = MEM_num_write;
    e_rw    = MEM_reg_write && MEM_num_write != 0 && !mis;
    e_pc    = MEM_pc;
    e_fault = mis;
    if (mis) e_faddr = MEM_c;
    if (MEM_mem_write && !mis) mmem[idx] = MEM_b;
  endtask

  // Present one instruction for one clock; return at the following falling edge.
  task automatic step(input bit rst, input bit [31:0] pc, input bit [31:0] b,
                      input bit [31:0] c, input bit [4:0] num, input bit mw,
                      input bit rw, input bit [1:0] sel);
    reset = rst; MEM_pc = pc; MEM_b = b; MEM_c = c; MEM_num_write = num;
    MEM_mem_write = mw; MEM_reg_write = rw; MEM_s_data_write = sel;
    @(posedge clock);
    model_step();
    chk_en = 1'b1;
    @(negedge clock);
  endtask

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of every WB output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      n_cmp++;
      if ((e_data_known && WB_data !== e_data) || WB_num_write !== e_num ||
          WB_reg_write !== e_rw || WB_pc !== e_pc || WB_fault !== e_fault ||
          fault_addr !== e_faddr) begin
        n_bad++;
        $display("FAIL model t=%0t: got data=%08h num=%0d rw=%b pc=%08h flt=%b fa=%08h, expected data=%08h(known=%b) num=%0d rw=%b pc=%08h flt=%b fa=%08h",
                 $time, WB_data, WB_num_write, WB_reg_write, WB_pc, WB_fault, fault_addr,
                 e_data, e_data_known, e_num, e_rw, e_pc, e_faddr == e_faddr ? e_fault : 1'b0, e_faddr);
      end
    end
  end

  localparam bit [1:0] ALU = 2'b00, LD = 2'b01, LNK = 2'b10, RSV = 2'b11;

  initial begin
    reset = 1'b1; MEM_pc = 0; MEM_b = 0; MEM_c = 0; MEM_num_write = 0;
    MEM_mem_write = 0; MEM_reg_write = 0; MEM_s_data_write = 0;
    @(negedge clock);

    // Reset for two cycles with a live-looking misaligned store presented.
    step(1, 32'h0040_0100, 32'h1111_1111, 32'h0000_0013, 5'd9, 1, 1, LD);
    step(1, 32'h0040_0104, 32'h2222_2222, 32'h0000_0020, 5'd9, 1, 1, LNK);
    check("rst_data", WB_data, 0);
    check("rst_rw", {31'd0, WB_reg_write}, 0);
    check("rst_faddr", fault_addr, 0);
    check("rst_pc", WB_pc, 0);

    // Store then load 0x10.
    step(0, 32'h0040_0000, 32'hDEAD_BEEF, 32'h0000_0010, 5'd0, 1, 0, ALU);
    step(0, 32'h0040_0004, 32'h0, 32'h0000_0010, 5'd3, 0, 1, LD);
    check("ld_0x10", WB_data, 32'hDEAD_BEEF);

    // Back-to-back store/load at 0x40 into r5.
    step(0, 32'h0040_0008, 32'h1234_5678, 32'h0000_0040, 5'd0, 1, 0, ALU);
    step(0, 32'h0040_000C, 32'h0, 32'h0000_0040, 5'd5, 0, 1, LD);
    check("ld_0x40", WB_data, 32'h1234_5678);
    check("ld_num", {27'd0, WB_num_write}, 5);
    check("ld_rw", {31'd0, WB_reg_write}, 1);

    // Link address, including 32-bit wrap.
    step(0, 32'h0040_0010, 32'h0, 32'h0000_0777, 5'd31, 0, 1, LNK);
    check("link", WB_data, 32'h0040_0014);
    step(0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0777, 5'd31, 0, 1, LNK);
    check("link_wrap", WB_data, 32'h0);

    // Misaligned store is dropped and faults.
    step(0, 32'h0040_0018, 32'hAAAA_AAAA, 32'h0000_0042, 5'd4, 1, 1, ALU);
    check("mis_st_fault", {31'd0, WB_fault}, 1);
    check("mis_st_faddr", fault_addr, 32'h42);
    check("mis_st_rw", {31'd0, WB_reg_write}, 0);
    step(0, 32'h0040_001C, 32'h0, 32'h0000_0040, 5'd6, 0, 1, LD);
    check("after_mis_st", WB_data, 32'h1234_5678);
    check("fault_1cyc", {31'd0, WB_fault}, 0);
    check("faddr_sticky", fault_addr, 32'h42);
    step(0, 32'h0040_0020, 32'h0, 32'h0000_0043, 5'd7, 0, 1, LD);
    check("mis_ld_rw", {31'd0, WB_reg_write}, 0);
    check("mis_ld_faddr", fault_addr, 32'h43);

    // ALU write to r0, and reserved select.
    step(0, 32'h0040_0024, 32'h0, 32'h0000_0055, 5'd0, 0, 1, ALU);
    check("r0_rw", {31'd0, WB_reg_write}, 0);
    check("r0_data", WB_data, 32'h55);
    step(0, 32'h0040_0028, 32'h0, 32'h0000_0066, 5'd8, 0, 1, RSV);
    check("rsv_data", WB_data, 32'h66);
    // Misaligned address with no memory access is not a fault.
    step(0, 32'h0040_002C, 32'h0, 32'h0000_0067, 5'd8, 0, 1, ALU);
    check("alu_odd_rw", {31'd0, WB_reg_write}, 1);

    // Address wrap: 0x1000 aliases 0x0000.
    step(0, 32'h0040_0030, 32'hCAFE_F00D, 32'h0000_1000, 5'd0, 1, 0, ALU);
    step(0, 32'h0040_0034, 32'h0, 32'h0000_0000, 5'd9, 0, 1, LD);
    check("wrap", WB_data, 32'hCAFE_F00D);

    // Bubble.
    step(0, 0, 0, 0, 0, 0, 0, ALU);
    check("bubble_rw", {31'd0, WB_reg_write}, 0);

    // Reset mid-stream: the store in the reset cycle must not land.
    step(0, 32'h0040_0038, 32'h0BAD_F00D, 32'h0000_0080, 5'd0, 1, 0, ALU);
    step(1, 32'h0040_003C, 32'hFFFF_FFFF, 32'h0000_0080, 5'd0, 1, 0, ALU);
    check("rst_mid_faddr", fault_addr, 0);
    step(0, 32'h0040_0040, 32'h0, 32'h0000_0080, 5'd10, 0, 1, LD);
    check("rst_mid_ld", WB_data, 32'h0BAD_F00D);
    check("rst_mid_rw", {31'd0, WB_reg_write}, 1);
    check("post_rst_faddr", fault_addr, 0);

    step(0, 0, 0, 0, 0, 0, 0, ALU);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
